// File: rtl/sram_serial_host.sv
// Serial load-port initiator for the SRAM_IO_CTRL block: turns one parallel request
// into a BGN/SI/LOAD_N/CTRL frame, waits for RDY, and captures SO on reads.
module sram_serial_host #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_WIDTH = ADDR_WIDTH + DATA_WIDTH,
    parameter int RDY_TIMEOUT = 32,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ,
    input  logic                  REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    output logic                  BUSY,
    output logic                  ACK,
    output logic                  ERR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  BGN,
    output logic                  SI,
    output logic                  LOAD_N,
    output logic [1:0]            CTRL,
    input  logic                  RDY,
    input  logic                  SO
);

    localparam int BW = $clog2(FRAME_WIDTH + 1);
    localparam int WW = $clog2(RDY_TIMEOUT + 1);
    localparam int RW = $clog2(DATA_WIDTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_WIDTH - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RDY_TIMEOUT - 1);
    localparam logic [RW-1:0] RD_LAST   = RW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_RDY, READ_SO, GAP} state_t;

    state_t                 state, state_d;
    logic [FRAME_WIDTH-1:0] frame;
    logic [DATA_WIDTH-1:0]  cap;
    logic [BW-1:0]          bit_cnt;
    logic [WW-1:0]          wait_cnt;
    logic [RW-1:0]          rd_cnt;
    logic [GW-1:0]          gap_cnt;
    logic                   rd_mode;
    logic                   rd_mode_d;
    logic                   timeout;
    logic                   accept;
    logic                   frame_on_d;

    always_comb begin
        state_d = state;
        timeout = 1'b0;
        case (state)
            IDLE:     if (REQ) state_d = SETUP;
            SETUP:    state_d = SHIFT;
            SHIFT:    if (bit_cnt == BIT_LAST) state_d = WAIT_RDY;
            WAIT_RDY: begin
                // RDY on the expiring cycle still counts as a normal completion
                if (RDY) begin
                    state_d = rd_mode ? READ_SO : GAP;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = GAP;
                    timeout = 1'b1;
                end
            end
            READ_SO:  if (rd_cnt == RD_LAST) state_d = GAP;
            GAP:      if (gap_cnt == GAP_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign accept     = (state == IDLE) && REQ;
    assign rd_mode_d  = accept ? ~REQ_WE : rd_mode;
    assign frame_on_d = (state_d == SETUP) || (state_d == SHIFT) ||
                        (state_d == WAIT_RDY) || (state_d == READ_SO);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            frame    <= '0;
            cap      <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            rd_cnt   <= '0;
            gap_cnt  <= '0;
            rd_mode  <= 1'b0;
            BUSY     <= 1'b0;
            ACK      <= 1'b0;
            ERR      <= 1'b0;
            RD_DATA  <= '0;
            BGN      <= 1'b0;
            SI       <= 1'b0;
            LOAD_N   <= 1'b1;
            CTRL     <= 2'b00;
        end else begin
            state    <= state_d;
            bit_cnt  <= (state == SHIFT)    ? bit_cnt + 1'b1  : '0;
            wait_cnt <= (state == WAIT_RDY) ? wait_cnt + 1'b1 : '0;
            rd_cnt   <= (state == READ_SO)  ? rd_cnt + 1'b1   : '0;
            gap_cnt  <= (state == GAP)      ? gap_cnt + 1'b1  : '0;

            // Frame is sent LSB first: data field, then address field
            if (accept) begin
                frame   <= {REQ_ADDR, REQ_WE ? REQ_DATA : {DATA_WIDTH{1'b0}}};
                rd_mode <= ~REQ_WE;
            end else if (state_d == SHIFT) begin
                frame <= {1'b0, frame[FRAME_WIDTH-1:1]};
            end

            if (state == READ_SO) begin
                cap <= {SO, cap[DATA_WIDTH-1:1]};
                if (rd_cnt == RD_LAST) RD_DATA <= {SO, cap[DATA_WIDTH-1:1]};
            end

            if (accept)       ERR <= 1'b0;
            else if (timeout) ERR <= 1'b1;

            // Outputs are decoded from the next state so they line up with it
            BUSY   <= (state_d != IDLE);
            ACK    <= (state_d == GAP) && (state != GAP);
            BGN    <= frame_on_d;
            LOAD_N <= (state_d == IDLE);
            SI     <= (state_d == SHIFT) ? frame[0] : 1'b0;
            CTRL   <= frame_on_d ? {1'b0, rd_mode_d} : 2'b00;
        end
    end

endmodule
